i2c_burst_writer: RTL and testbench

- Synthesizable I2C master that performs one burst register write per command: START, 7-bit slave address + W, register address, then N data bytes, then STOP.
- Successor to the bench-side sequential gain-write sequence, in hardware form: byte count set per command, bus timing set by parameter, data pulled from a valid/ready stream, and ACK checked on every byte.
- Sits between control logic (gain preset loader, 10-band EQ at slave address 0x6A) and the open-drain SCL/SDA pads.

---
 rtl/i2c_burst_writer_if.sv | 30 +++
 rtl/i2c_burst_writer.sv | 173 +++++++++++++++++
 tb/tb_i2c_burst_writer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_burst_writer_if.sv
// Command/stream/pad bundle for the I2C burst writer. The "master" modport is the
// controlling side (commands, data stream, SDA pad level); "slave" is the writer itself.
interface i2c_burst_writer_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic [6:0]       slave_addr;
  logic [7:0]       start_reg;
  logic [CNT_W-1:0] byte_count;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             scl_oe;
  logic             sda_oe;
  logic             sda_i;
  logic             busy;
  logic             done;
  logic             ack_error;
  logic [CNT_W-1:0] bytes_sent;

  modport master (
    output start, slave_addr, start_reg, byte_count, in_data, in_valid, sda_i,
    input  in_ready, scl_oe, sda_oe, busy, done, ack_error, bytes_sent
  );

  modport slave (
    input  start, slave_addr, start_reg, byte_count, in_data, in_valid, sda_i,
    output in_ready, scl_oe, sda_oe, busy, done, ack_error, bytes_sent
  );
endinterface

// File: rtl/i2c_burst_writer.sv
// I2C master for one burst register write per command: START, addr+W, register,
// N streamed data bytes with per-byte ACK check, STOP. All pad changes land on quarter-bit boundaries.
module i2c_burst_writer #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 16,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  i2c_burst_writer_if.slave bus
);
  localparam int               QW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0]    Q_LAST = QW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] N_MAX  = CNT_W'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, START, ADDR, REG, DATA, WAIT, STOP} state_t;

  state_t           state;
  logic [QW-1:0]    qcnt;
  logic [1:0]       qtr;
  logic [3:0]       bit_idx;    // 0..7 data bits, 8 = ACK bit
  logic [6:0]       shreg;      // bits still to send after the one on SDA
  logic [6:0]       addr_q;
  logic [7:0]       reg_q;
  logic [CNT_W-1:0] remaining;
  logic             ack_smp;
  logic             scl_q, sda_q, busy_q, done_q, err_q;
  logic [CNT_W-1:0] sent_q;

  logic tick, byte_end, more, fetch;

  always_comb begin
    tick     = busy_q && (qcnt == Q_LAST);
    byte_end = tick && (qtr == 2'd3) && (bit_idx == 4'd8) && (state inside {ADDR, REG, DATA});
    // In REG nothing has been sent yet; in DATA the current byte is still counted.
    more     = (state == REG) ? (remaining != '0) : (remaining > CNT_W'(1));
    fetch    = tick && bus.in_valid &&
               ((state == WAIT) || (byte_end && !ack_smp && (state != ADDR) && more));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      qcnt      <= '0;
      qtr       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      addr_q    <= '0;
      reg_q     <= '0;
      remaining <= '0;
      ack_smp   <= 1'b0;
      scl_q     <= 1'b0;
      sda_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sent_q    <= '0;
    end else begin
      done_q <= 1'b0;
      qcnt   <= (!busy_q || tick) ? '0 : qcnt + 1'b1;
      if (tick && (qtr == 2'd1) && (state inside {ADDR, REG, DATA}))
        ack_smp <= bus.sda_i;

      case (state)
        IDLE: if (bus.start) begin
          busy_q    <= 1'b1;
          state     <= START;
          err_q     <= 1'b0;
          sent_q    <= '0;
          addr_q    <= bus.slave_addr;
          reg_q     <= bus.start_reg;
          remaining <= (bus.byte_count > N_MAX) ? N_MAX : bus.byte_count;
          qtr       <= '0;
          scl_q     <= 1'b0;
          sda_q     <= 1'b0;
        end

        START: if (tick) begin
          qtr <= qtr + 1'b1;
          case (qtr)
            2'd0: sda_q <= 1'b1;
            2'd1: scl_q <= 1'b1;
            default: begin
              qtr     <= '0;
              bit_idx <= '0;
              sda_q   <= ~addr_q[6];
              shreg   <= {addr_q[5:0], 1'b0};
              state   <= ADDR;
            end
          endcase
        end

        ADDR, REG, DATA: if (tick) begin
          qtr <= qtr + 1'b1;
          case (qtr)
            2'd0: scl_q <= 1'b0;
            2'd2: scl_q <= 1'b1;
            2'd3: begin
              if (bit_idx != 4'd8) begin
                bit_idx <= bit_idx + 1'b1;
                if (bit_idx == 4'd7) begin
                  sda_q <= 1'b0;
                end else begin
                  sda_q <= ~shreg[6];
                  shreg <= {shreg[5:0], 1'b0};
                end
              end else if (ack_smp) begin
                // NACK: abandon the rest of the burst without fetching it.
                err_q <= 1'b1;
                sda_q <= 1'b1;
                state <= STOP;
              end else if (state == ADDR) begin
                bit_idx <= '0;
                sda_q   <= ~reg_q[7];
                shreg   <= reg_q[6:0];
                state   <= REG;
              end else begin
                if (state == DATA) begin
                  sent_q    <= sent_q + 1'b1;
                  remaining <= remaining - 1'b1;
                end
                if (!more) begin
                  sda_q <= 1'b1;
                  state <= STOP;
                end else if (fetch) begin
                  bit_idx <= '0;
                  sda_q   <= ~bus.in_data[7];
                  shreg   <= bus.in_data[6:0];
                  state   <= DATA;
                end else begin
                  state <= WAIT;
                end
              end
            end
            default: ;
          endcase
        end

        // SCL stays low (master stretch) until the stream has a byte ready.
        WAIT: if (fetch) begin
          bit_idx <= '0;
          sda_q   <= ~bus.in_data[7];
          shreg   <= bus.in_data[6:0];
          state   <= DATA;
        end

        STOP: if (tick) begin
          qtr <= qtr + 1'b1;
          case (qtr)
            2'd0: scl_q <= 1'b0;
            2'd1: sda_q <= 1'b0;
            default: begin
              qtr    <= '0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end
          endcase
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.scl_oe     = scl_q;
  assign bus.sda_oe     = sda_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ack_error  = err_q;
  assign bus.bytes_sent = sent_q;
  assign bus.in_ready   = fetch;
endmodule

// File: tb/tb_i2c_burst_writer.sv
// Bench for i2c_burst_writer: bus-level slave/monitor, data-stream feeder and a
// frame-level reference model (bytes on the wire, counts, frame length in quarters).
module tb_i2c_burst_writer;
  localparam int CLK_DIV   = 4;
  localparam int MAX_BYTES = 16;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);
  localparam logic [6:0] SLAVE = 7'h6A;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_burst_writer_if #(.CNT_W(CNT_W)) bif();

  i2c_burst_writer #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Data stream source: feeder owns feed_idx/stalling, the stimulus owns src/src_n.
  logic [7:0] src [0:4095];
  int src_n     = 0;
  int feed_idx  = 0;
  int stall_at  = -1;
  int stall_len = 0;
  logic stalling = 1'b0;

  assign bif.in_valid = (feed_idx < src_n) && !stalling;
  assign bif.in_data  = src[feed_idx[11:0]];

  always @(negedge clk) begin
    if (bif.in_ready === 1'b1) begin
      @(posedge clk); #1;
      feed_idx++;
      if (feed_idx == stall_at) begin
        stalling = 1'b1;
        repeat (stall_len) @(posedge clk);
        #1 stalling = 1'b0;
      end
    end
  end

  // Open-drain slave at SLAVE plus bus decoder.
  logic slave_pull = 1'b0;
  assign bif.sda_i = ~(bif.sda_oe | slave_pull);

  logic [7:0] mon_q[$];
  logic [7:0] shf = 8'h00;
  logic scl_p = 1'b1, sda_p = 1'b1, in_frame = 1'b0;
  int nbit = 0, bidx = 0, n_start = 0, n_stop = 0, nack_at = -1;
  int low_run = 0, max_low = 0, ready_cnt = 0;

  always @(negedge clk) begin
    logic scl, sda;
    scl = ~bif.scl_oe;
    sda = bif.sda_i;
    if (bif.in_ready === 1'b1) ready_cnt++;
    if (!scl) begin
      low_run++;
      if (low_run > max_low) max_low = low_run;
    end else low_run = 0;
    if (rst) begin
      slave_pull = 1'b0;
      in_frame   = 1'b0;
    end else if (scl && scl_p && sda_p && !sda) begin
      n_start++; mon_q.delete(); nbit = 0; bidx = 0; in_frame = 1'b1; max_low = 0;
    end else if (scl && scl_p && !sda_p && sda) begin
      n_stop++; in_frame = 1'b0;
    end else if (in_frame && scl && !scl_p) begin
      if (nbit < 8) shf = {shf[6:0], sda};
      nbit++;
      if (nbit == 9) begin mon_q.push_back(shf); nbit = 0; bidx++; end
    end else if (in_frame && !scl && scl_p) begin
      if (nbit == 8) slave_pull = !(bidx == 0 && shf[7:1] != SLAVE) && (bidx != nack_at);
      else           slave_pull = 1'b0;
    end
    scl_p = scl;
    sda_p = sda;
  end

  task automatic run(input string tag, input logic [6:0] a, input logic [7:0] r,
                     input int cnt, input int nack_data, input int gap, input bit seq,
                     input int poke_at, input int abort_at);
    int n_eff, base, cyc, budget, s0, p0, r0, extra, fetched, exp_sent, exp_cyc;
    logic exp_err;
    logic [7:0] exp_q[$];
    n_eff = (cnt > MAX_BYTES) ? MAX_BYTES : cnt;
    base  = feed_idx;
    for (int i = 0; i < n_eff; i++) src[base+i] = seq ? 8'(8'h11 + i) : 8'($urandom);
    src_n     = base + n_eff;
    nack_at   = (nack_data >= 0) ? nack_data + 2 : -1;
    stall_at  = (gap > 0) ? base + 1 : -1;
    stall_len = 36 * CLK_DIV + gap;

    // Reference: bytes the slave sees, stopping at the first NACK.
    exp_err = 1'b0; exp_sent = 0;
    exp_q.push_back({a, 1'b0});
    if (a != SLAVE) exp_err = 1'b1;
    else begin
      exp_q.push_back(r);
      for (int i = 0; i < n_eff; i++) begin
        exp_q.push_back(src[base+i]);
        if (i == nack_data) begin exp_err = 1'b1; break; end
        exp_sent++;
      end
    end
    fetched = (exp_q.size() > 2) ? exp_q.size() - 2 : 0;
    extra   = (gap > 0 && fetched >= 2) ? ((gap + CLK_DIV) / CLK_DIV) * CLK_DIV : 0;
    exp_cyc = (6 + 36 * exp_q.size()) * CLK_DIV + extra;
    budget  = exp_cyc + 400;

    s0 = n_start; p0 = n_stop; r0 = ready_cnt;
    @(posedge clk); #1;
    bif.slave_addr = a;
    bif.start_reg  = r;
    bif.byte_count = CNT_W'(cnt);
    bif.start      = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    check({tag, " busy_rise"}, 32'(bif.busy), 32'd1);
    check({tag, " err_clr"}, 32'(bif.ack_error), 32'd0);
    check({tag, " sent_clr"}, 32'(bif.bytes_sent), 32'd0);

    cyc = 0;
    while (bif.done !== 1'b1 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      bif.start      = (cyc == poke_at);
      bif.slave_addr = (cyc == poke_at) ? 7'h11 : a;
      if (cyc == abort_at) begin
        check({tag, " busy_before_rst"}, 32'(bif.busy), 32'd1);
        rst = 1'b1;
        #1;
        check({tag, " rst_scl"}, 32'(bif.scl_oe), 32'd0);
        check({tag, " rst_sda"}, 32'(bif.sda_oe), 32'd0);
        check({tag, " rst_busy"}, 32'(bif.busy), 32'd0);
        check({tag, " rst_ready"}, 32'(bif.in_ready), 32'd0);
        check({tag, " rst_sent"}, 32'(bif.bytes_sent), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
    end
    check({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " busy_fall"}, 32'(bif.busy), 32'd0);
    check({tag, " ack_error"}, 32'(bif.ack_error), 32'(exp_err));
    check({tag, " bytes_sent"}, 32'(bif.bytes_sent), 32'(exp_sent));
    check({tag, " nbytes"}, 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s byte%0d", tag, i),
            (i < mon_q.size()) ? 32'(mon_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    check({tag, " stop"}, 32'(n_stop - p0), 32'd1);
    check({tag, " in_ready"}, 32'(ready_cnt - r0), 32'(fetched));
    if (gap > 0) check({tag, " scl_low_max"}, 32'(max_low), 32'(2 * CLK_DIV + extra));
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 32'(bif.done), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check({tag, " one_frame"}, 32'(n_start - s0), 32'd1);
    check({tag, " idle"}, 32'(bif.busy), 32'd0);
  endtask

  initial begin
    int cnt, nd;
    bif.start = 1'b0; bif.slave_addr = '0; bif.start_reg = '0; bif.byte_count = '0;
    #1 rst = 1'b1;
    #1;
    check("reset scl_oe", 32'(bif.scl_oe), 32'd0);
    check("reset sda_oe", 32'(bif.sda_oe), 32'd0);
    check("reset busy", 32'(bif.busy), 32'd0);
    check("reset done", 32'(bif.done), 32'd0);
    check("reset in_ready", 32'(bif.in_ready), 32'd0);
    check("reset ack_error", 32'(bif.ack_error), 32'd0);
    check("reset bytes_sent", 32'(bif.bytes_sent), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run("burst10", SLAVE, 8'h01, 10, -1, 0, 1'b1, 0, 0);
    run("count0", SLAVE, 8'h07, 0, -1, 0, 1'b1, 0, 0);
    run("addr_nack", 7'h6B, 8'h01, 4, -1, 0, 1'b1, 0, 0);
    run("data_nack", SLAVE, 8'h08, 3, 2, 0, 1'b0, 0, 0);
    run("stall", SLAVE, 8'h01, 10, -1, 50, 1'b1, 0, 0);
    run("clamp", SLAVE, 8'h40, 20, -1, 0, 1'b0, 0, 0);
    run("busy_start", SLAVE, 8'h20, 2, -1, 0, 1'b0, 100, 0);
    run("abort", SLAVE, 8'h30, 5, -1, 0, 1'b0, 0, (6 + 36 * 2 + 10) * CLK_DIV);
    run("after_rst", SLAVE, 8'h31, 3, -1, 0, 1'b0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cnt = int'($urandom_range(0, MAX_BYTES));
      nd  = (cnt > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
      run($sformatf("rnd%0d", k), SLAVE, 8'($urandom), cnt, nd, 0, 1'b0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
